// File: rtl/neo_sync_delay_line_pkg.sv
// Shared helpers for neo_sync_delay_line: delay-select width and clamp.
// Every user of the delay line imports this package so that the DELAY bus
// width and the clamp rule stay identical across instances.
package neo_sync_delay_line_pkg;

    // Width of a bus able to hold 0..depth inclusive.
    function automatic int unsigned neo_dly_dw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Requests beyond the number of physical stages fall back to the longest tap.
    function automatic int unsigned neo_dly_clamp(input int unsigned req,
                                                  input int unsigned depth);
        return (req > depth) ? depth : req;
    endfunction

endpackage

// File: rtl/neo_sync_delay_line_stage.sv
// One storage stage of the delay line: WIDTH-bit register that advances on
// ce_i and returns to RESET_VAL on a synchronous clear. The clear has
// priority so a flush always discards the sample presented that cycle.
module neo_sync_delay_line_stage #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             ce_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: clear beats enable, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = RESET_VAL;
        end else if (ce_i) begin
            data_d = d_i;
        end
    end

    // Stage register with asynchronous reset.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/neo_sync_delay_line.sv
// Clocked delay line: delays in_i by 0..DEPTH clock-enable ticks, selected at
// runtime through delay_i (values above DEPTH clamp to DEPTH). valid_o tells
// whether the tapped stage holds real input rather than reset/flush fill.
// Optional per-bit edge pulses on the output are built only when the macro
// NEO_DELAY_LINE_EDGE_EN is defined; otherwise rise_o/fall_o are tied low.
module neo_sync_delay_line
    import neo_sync_delay_line_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk_i,
    input  logic                         nreset_i,
    input  logic                         ce_i,
    input  logic                         flush_i,
    input  logic [neo_dly_dw(DEPTH)-1:0] delay_i,
    input  logic [WIDTH-1:0]             in_i,
    output logic [WIDTH-1:0]             out_o,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             rise_o,
    output logic [WIDTH-1:0]             fall_o
);

    localparam int unsigned     DW      = neo_dly_dw(DEPTH);
    localparam logic [DW-1:0]   DEPTH_C = DW'(DEPTH);

    logic [DW-1:0]    delay_q;
    logic [DW-1:0]    delay_d;
    logic [DW-1:0]    fill_q;
    logic [DW-1:0]    fill_d;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] out_w;
    logic             valid_w;

    // Clamp the requested delay; sampled every clock, independent of ce_i.
    always_comb begin
        delay_d = DW'(neo_dly_clamp(32'(delay_i), DEPTH));
    end

    // Delay-select register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            delay_q <= '0;
        end else begin
            delay_q <= delay_d;
        end
    end

    // Shift chain: stage 0 takes in_i, each later stage takes its predecessor.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_d;
        if (k == 0) begin : g_head
            assign stage_d = in_i;
        end else begin : g_body
            assign stage_d = stage_q[k-1];
        end
        neo_sync_delay_line_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk_i    (clk_i),
            .nreset_i (nreset_i),
            .ce_i     (ce_i),
            .clr_i    (flush_i),
            .d_i      (stage_d),
            .q_o      (stage_q[k])
        );
    end

    // Tap mux: delay 0 bypasses the chain, delay N reads stage N-1.
    always_comb begin
        out_w = in_i;
        for (int k = 0; k < DEPTH; k++) begin
            if (delay_q == DW'(k + 1)) begin
                out_w = stage_q[k];
            end
        end
    end

    // Fill count: how many real samples the chain holds, saturating at DEPTH.
    always_comb begin
        fill_d = fill_q;
        if (flush_i) begin
            fill_d = '0;
        end else if (ce_i && (fill_q != DEPTH_C)) begin
            fill_d = DW'(fill_q + 1'b1);
        end
    end

    // Fill count register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // Tapped stage is real data once at least delay_q samples have entered.
    assign valid_w = (fill_q >= delay_q);

    assign out_o   = out_w;
    assign valid_o = valid_w;

`ifdef NEO_DELAY_LINE_EDGE_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    // Remember the output as it was just before each CE tick.
    always_comb begin
        prev_d = prev_q;
        if (flush_i) begin
            prev_d = RESET_VAL;
        end else if (ce_i) begin
            prev_d = out_w;
        end
    end

    // Previous-output register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = out_w & ~prev_q & {WIDTH{valid_w}};
    assign fall_o = ~out_w & prev_q & {WIDTH{valid_w}};
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: tb/tb_neo_sync_delay_line.sv
module tb_neo_sync_delay_line;

    logic       clk_i;
    logic       nreset_i;
    logic       ce_i;
    logic       flush_i;
    logic [2:0] delay_i;
    logic [7:0] in_i;
    logic [7:0] out_o;
    logic       valid_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;

    int vectors;
    int miscompares;

    neo_sync_delay_line #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .ce_i     (ce_i),
        .flush_i  (flush_i),
        .delay_i  (delay_i),
        .in_i     (in_i),
        .out_o    (out_o),
        .valid_o  (valid_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        ce_i     = 1'b0;
        flush_i  = 1'b0;
        nreset_i = 1'b0;
        #2;
        nreset_i = 1'b1;
    endtask

    task automatic test_reset();
        nreset_i = 1'b0; ce_i = 1'b0; flush_i = 1'b0; delay_i = 3'd2; in_i = 8'h3C;
        #2;
        vectors++; if (out_o !== 8'h3C) begin miscompares++; $display("FAIL rst_bypass: got %h want %h", out_o, 8'h3C); end
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL rst_valid: got %b want 1", valid_o); end
        in_i = 8'h00;
        #1;
        vectors++; if (rise_o !== 8'h00 || fall_o !== 8'h00) begin miscompares++; $display("FAIL rst_edges: got rise %h fall %h want 00/00", rise_o, fall_o); end
        nreset_i = 1'b1; ce_i = 1'b1; in_i = 8'h77;
        tick();
        vectors++; if (out_o !== 8'h00) begin miscompares++; $display("FAIL rst_first_tick_out: got %h want %h", out_o, 8'h00); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_first_tick_valid: got %b want 0", valid_o); end
        ce_i = 1'b0;
    endtask

    task automatic test_fill_latency();
        logic [7:0] ins  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] outs [4] = '{8'h00, 8'h00, 8'h11, 8'h22};
        logic       vals [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        reset_dut();
        delay_i = 3'd3; ce_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_i = ins[i];
            tick();
            vectors++; if (out_o !== outs[i]) begin miscompares++; $display("FAIL fill_out[%0d]: got %h want %h", i, out_o, outs[i]); end
            vectors++; if (valid_o !== vals[i]) begin miscompares++; $display("FAIL fill_valid[%0d]: got %b want %b", i, valid_o, vals[i]); end
        end
        ce_i = 1'b0;
    endtask

    task automatic test_ce_gating();
        logic       ces  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] ins  [5] = '{8'hA5, 8'h5A, 8'h5A, 8'hEE, 8'h00};
        logic [7:0] outs [5] = '{8'h00, 8'h00, 8'hA5, 8'hA5, 8'h5A};
        logic       vals [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        reset_dut();
        delay_i = 3'd2;
        for (int i = 0; i < 5; i++) begin
            ce_i = ces[i]; in_i = ins[i];
            tick();
            vectors++; if (out_o !== outs[i]) begin miscompares++; $display("FAIL ce_out[%0d]: got %h want %h", i, out_o, outs[i]); end
            vectors++; if (valid_o !== vals[i]) begin miscompares++; $display("FAIL ce_valid[%0d]: got %b want %b", i, valid_o, vals[i]); end
        end
        ce_i = 1'b0;
    endtask

    task automatic test_flush();
        logic [7:0] ins  [4] = '{8'h02, 8'h03, 8'h03, 8'h03};
        logic [7:0] outs [4] = '{8'h00, 8'h00, 8'h00, 8'h02};
        logic       vals [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        reset_dut();
        delay_i = 3'd4; ce_i = 1'b1; in_i = 8'hFF;
        repeat (4) tick();
        vectors++; if (out_o !== 8'hFF || valid_o !== 1'b1) begin miscompares++; $display("FAIL flush_full: got %h/%b want ff/1", out_o, valid_o); end
        flush_i = 1'b1; in_i = 8'h01;
        tick();
        flush_i = 1'b0;
        vectors++; if (out_o !== 8'h00) begin miscompares++; $display("FAIL flush_out: got %h want %h", out_o, 8'h00); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", valid_o); end
        for (int i = 0; i < 4; i++) begin
            in_i = ins[i];
            tick();
            vectors++; if (out_o !== outs[i]) begin miscompares++; $display("FAIL flush_after_out[%0d]: got %h want %h", i, out_o, outs[i]); end
            vectors++; if (valid_o !== vals[i]) begin miscompares++; $display("FAIL flush_after_valid[%0d]: got %b want %b", i, valid_o, vals[i]); end
        end
        ce_i = 1'b0;
    endtask

    task automatic test_delay_change();
        reset_dut();
        delay_i = 3'd1; ce_i = 1'b1;
        in_i = 8'h10; tick();
        vectors++; if (out_o !== 8'h10 || valid_o !== 1'b1) begin miscompares++; $display("FAIL dly1_a: got %h/%b want 10/1", out_o, valid_o); end
        in_i = 8'h20; tick();
        vectors++; if (out_o !== 8'h20 || valid_o !== 1'b1) begin miscompares++; $display("FAIL dly1_b: got %h/%b want 20/1", out_o, valid_o); end
        delay_i = 3'd4; ce_i = 1'b0; tick();
        vectors++; if (out_o !== 8'h00 || valid_o !== 1'b0) begin miscompares++; $display("FAIL dly4_retap: got %h/%b want 00/0", out_o, valid_o); end
        ce_i = 1'b1; in_i = 8'h30; tick();
        vectors++; if (out_o !== 8'h00 || valid_o !== 1'b0) begin miscompares++; $display("FAIL dly4_fill3: got %h/%b want 00/0", out_o, valid_o); end
        in_i = 8'h40; tick();
        vectors++; if (out_o !== 8'h10 || valid_o !== 1'b1) begin miscompares++; $display("FAIL dly4_fill4: got %h/%b want 10/1", out_o, valid_o); end
        ce_i = 1'b0; delay_i = 3'd1; tick();
        vectors++; if (out_o !== 8'h40 || valid_o !== 1'b1) begin miscompares++; $display("FAIL dly_shorter: got %h/%b want 40/1", out_o, valid_o); end
        delay_i = 3'd7; tick();
        vectors++; if (out_o !== 8'h10 || valid_o !== 1'b1) begin miscompares++; $display("FAIL dly_clamp: got %h/%b want 10/1", out_o, valid_o); end
        ce_i = 1'b1; in_i = 8'h50; tick();
        vectors++; if (out_o !== 8'h20 || valid_o !== 1'b1) begin miscompares++; $display("FAIL dly_saturate: got %h/%b want 20/1", out_o, valid_o); end
        ce_i = 1'b0; delay_i = 3'd0; in_i = 8'h99; tick();
        vectors++; if (out_o !== 8'h99 || valid_o !== 1'b1) begin miscompares++; $display("FAIL dly0_a: got %h/%b want 99/1", out_o, valid_o); end
        in_i = 8'h66; #1;
        vectors++; if (out_o !== 8'h66) begin miscompares++; $display("FAIL dly0_comb: got %h want 66", out_o); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        delay_i = 3'd2; ce_i = 1'b1; in_i = 8'hC3;
        repeat (3) tick();
        vectors++; if (out_o !== 8'hC3) begin miscompares++; $display("FAIL arst_pre: got %h want c3", out_o); end
        in_i = 8'h5E; nreset_i = 1'b0; #1;
        vectors++; if (out_o !== 8'h5E || valid_o !== 1'b1) begin miscompares++; $display("FAIL arst_immediate: got %h/%b want 5e/1", out_o, valid_o); end
        nreset_i = 1'b1; in_i = 8'h12; tick();
        vectors++; if (out_o !== 8'h00 || valid_o !== 1'b0) begin miscompares++; $display("FAIL arst_cleared: got %h/%b want 00/0", out_o, valid_o); end
        ce_i = 1'b0;
    endtask

    task automatic test_edge();
        logic [7:0] ins   [5] = '{8'h00, 8'h81, 8'h81, 8'h81, 8'h00};
        logic       ces   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] rises [5];
        logic [7:0] falls [5];
`ifdef NEO_DELAY_LINE_EDGE_EN
        rises = '{8'h00, 8'h81, 8'h81, 8'h00, 8'h00};
        falls = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
`else
        rises = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        falls = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        reset_dut();
        delay_i = 3'd1;
        for (int i = 0; i < 5; i++) begin
            ce_i = ces[i]; in_i = ins[i];
            tick();
            vectors++; if (rise_o !== rises[i]) begin miscompares++; $display("FAIL edge_rise[%0d]: got %h want %h", i, rise_o, rises[i]); end
            vectors++; if (fall_o !== falls[i]) begin miscompares++; $display("FAIL edge_fall[%0d]: got %h want %h", i, fall_o, falls[i]); end
        end
        ce_i = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        nreset_i = 1'b0; ce_i = 1'b0; flush_i = 1'b0; delay_i = 3'd0; in_i = 8'h00;
        test_reset();
        test_fill_latency();
        test_ce_gating();
        test_flush();
        test_delay_change();
        test_async_reset();
        test_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
